// File: rtl/key_sel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_sel_ctrl_pkg
// Brief    : Shared debouncer state encodings and default qualification count.
// Revision : 1.0
// ============================================================================
package key_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms of stable level at 50 MHz
    localparam int c_cnt_max_default = 1000000;

endpackage
`default_nettype wire

// File: rtl/key_filter.sv
`default_nettype none
// ============================================================================
// Module   : key_filter
// Brief    : Two-flop synchronizer, four-state debouncer and one-cycle press pulse.
// Revision : 1.0
// ============================================================================
module key_filter
    import key_sel_ctrl_pkg::*;
#(
    parameter int CNT_MAX = c_cnt_max_default
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press
);

    localparam int              c_cw   = $clog2(CNT_MAX + 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);
    localparam logic [c_cw-1:0] c_last = c_cw'(CNT_MAX - 1);
    localparam logic [c_cw-1:0] c_max  = c_cw'(CNT_MAX);

    logic [1:0]      r_sync;
    key_state_t      r_state;
    key_state_t      w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [c_cw-1:0] w_cnt_inc;
    logic            r_press;
    logic            w_press_nxt;
    logic            w_in;

    assign w_in      = r_sync[1];
    assign w_cnt_inc = (r_cnt == c_max) ? r_cnt : r_cnt + c_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    // The sample that leaves a stable state counts as the first qualifying one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        case (r_state)
            RELEASED: begin
                if (!w_in) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = c_one;
                end
            end
            PRESS_WAIT: begin
                if (w_in) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_last) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            PRESSED: begin
                if (w_in) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = c_one;
                end
            end
            RELEASE_WAIT: begin
                if (!w_in) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_last) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level = !((r_state == PRESSED) || (r_state == RELEASE_WAIT));
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/key_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_sel_ctrl
// Brief    : Debounces eight data keys plus Step/En buttons and drives 8:1 selector controls.
// Revision : 1.0
// ============================================================================
module key_sel_ctrl
    import key_sel_ctrl_pkg::*;
#(
    parameter int CNT_MAX = c_cnt_max_default
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Key_Raw,
    input  logic       Step_n,
    input  logic       En_n,
    input  logic       Dir,
    output logic [7:0] Key_Out,
    output logic [2:0] Sel_Out,
    output logic       CSn_Out
);

    logic [7:0] w_key_level;
    logic [7:0] w_key_press_unused;
    logic       w_step_level_unused;
    logic       w_en_level_unused;
    logic       w_step_press;
    logic       w_en_press;
    logic [1:0] r_dir_sync;
    logic [7:0] r_key_out;
    logic [2:0] r_sel;
    logic       r_csn;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_key
            key_filter #(.CNT_MAX(CNT_MAX)) u_key_filter (
                .clk     (Clk),
                .rst     (Reset),
                .i_key_n (Key_Raw[i]),
                .o_level (w_key_level[i]),
                .o_press (w_key_press_unused[i])
            );
        end
    endgenerate

    key_filter #(.CNT_MAX(CNT_MAX)) u_step_filter (
        .clk     (Clk),
        .rst     (Reset),
        .i_key_n (Step_n),
        .o_level (w_step_level_unused),
        .o_press (w_step_press)
    );

    key_filter #(.CNT_MAX(CNT_MAX)) u_en_filter (
        .clk     (Clk),
        .rst     (Reset),
        .i_key_n (En_n),
        .o_level (w_en_level_unused),
        .o_press (w_en_press)
    );

    // Step gating reads r_csn before this cycle's toggle lands.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dir_sync <= 2'b00;
            r_key_out  <= 8'hFF;
            r_sel      <= 3'd0;
            r_csn      <= 1'b1;
        end else begin
            r_dir_sync <= {r_dir_sync[0], Dir};
            r_key_out  <= w_key_level;
            if (w_en_press) begin
                r_csn <= ~r_csn;
            end
            if (w_step_press && !r_csn) begin
                r_sel <= r_dir_sync[1] ? r_sel - 3'd1 : r_sel + 3'd1;
            end
        end
    end

    assign Key_Out = r_key_out;
    assign Sel_Out = r_sel;
    assign CSn_Out = r_csn;

endmodule
`default_nettype wire

// File: tb/tb_key_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_sel_ctrl
// Brief    : Self-checking bench for key_sel_ctrl with CNT_MAX=4.
// Revision : 1.0
// ============================================================================
module tb_key_sel_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Key_Raw;
    logic       Step_n;
    logic       En_n;
    logic       Dir;
    logic [7:0] Key_Out;
    logic [2:0] Sel_Out;
    logic       CSn_Out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [11:0] val;
    } exp_t;

    typedef struct {
        logic [7:0] key;
        logic       step_n;
        logic       en_n;
        logic       dir;
        logic [7:0] exp_key;
        logic [2:0] exp_sel;
        logic       exp_csn;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[15];

    key_sel_ctrl #(.CNT_MAX(4)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Key_Raw (Key_Raw),
        .Step_n  (Step_n),
        .En_n    (En_n),
        .Dir     (Dir),
        .Key_Out (Key_Out),
        .Sel_Out (Sel_Out),
        .CSn_Out (CSn_Out)
    );

    always #5 Clk = ~Clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input string n, input logic [7:0] k, input logic [2:0] s, input logic c);
        exp_t e;
        e.name = n;
        e.val  = {k, s, c};
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t        e;
        logic [11:0] obs;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e   = exp_q.pop_front();
            obs = {Key_Out, Sel_Out, CSn_Out};
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got key=%h sel=%0d csn=%b, want key=%h sel=%0d csn=%b",
                         e.name, obs[11:4], obs[3:1], obs[0], e.val[11:4], e.val[3:1], e.val[0]);
            end
        end
    endtask

    task automatic expect_now(input string n, input logic [7:0] k, input logic [2:0] s, input logic c);
        push_exp(n, k, s, c);
        pop_cmp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // key, step_n, en_n, dir, exp_key, exp_sel, exp_csn
        tbl[0]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[1]  = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 3'd1, 1'b0};
        tbl[2]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 3'd2, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0};
        tbl[4]  = '{8'h81, 1'b0, 1'b1, 1'b0, 8'h81, 3'd4, 1'b0};
        tbl[5]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 3'd5, 1'b0};
        tbl[6]  = '{8'h7E, 1'b0, 1'b1, 1'b0, 8'h7E, 3'd6, 1'b0};
        tbl[7]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 3'd7, 1'b0};
        tbl[8]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 3'd0, 1'b0};
        tbl[9]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 3'd1, 1'b0};
        tbl[10] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 3'd0, 1'b0};
        tbl[11] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 3'd7, 1'b0};
        tbl[12] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 3'd7, 1'b1};
        tbl[13] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 3'd7, 1'b1};
        tbl[14] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 3'd7, 1'b0};

        Reset   = 1'b1;
        Key_Raw = 8'hFF;
        Step_n  = 1'b1;
        En_n    = 1'b1;
        Dir     = 1'b0;
        cyc(3);
        Reset = 1'b0;
        expect_now("reset_state", 8'hFF, 3'd0, 1'b1);

        // Key_Out[3] must fall on the 6th edge after the first sampling edge.
        Key_Raw = 8'hF7;
        for (int k = 0; k <= 6; k++) begin
            cyc(1);
            expect_now($sformatf("key3_latency_e%0d", k), (k == 6) ? 8'hF7 : 8'hFF, 3'd0, 1'b1);
        end
        Key_Raw = 8'hFF;
        cyc(8);
        expect_now("key3_release", 8'hFF, 3'd0, 1'b1);

        // Three-cycle glitch on Key_Raw[5] must never reach the outputs.
        Key_Raw = 8'hDF;
        cyc(3);
        Key_Raw = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            expect_now($sformatf("key5_glitch_c%0d", k), 8'hFF, 3'd0, 1'b1);
        end

        for (int i = 0; i < 15; i++) begin
            Key_Raw = tbl[i].key;
            Step_n  = tbl[i].step_n;
            En_n    = tbl[i].en_n;
            Dir     = tbl[i].dir;
            cyc(10);
            push_exp($sformatf("vec%0d_held", i), tbl[i].exp_key, tbl[i].exp_sel, tbl[i].exp_csn);
            pop_cmp();
            Key_Raw = 8'hFF;
            Step_n  = 1'b1;
            En_n    = 1'b1;
            cyc(10);
            push_exp($sformatf("vec%0d_released", i), 8'hFF, tbl[i].exp_sel, tbl[i].exp_csn);
            pop_cmp();
        end

        // Reset two cycles into a Step qualification, Step still held after.
        Dir    = 1'b0;
        Step_n = 1'b0;
        cyc(4);
        expect_now("pre_reset_hold", 8'hFF, 3'd7, 1'b0);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        expect_now("reset_mid_qual", 8'hFF, 3'd0, 1'b1);
        cyc(12);
        expect_now("requal_ignored", 8'hFF, 3'd0, 1'b1);
        Step_n = 1'b1;
        cyc(10);
        expect_now("after_step_release", 8'hFF, 3'd0, 1'b1);

        // Controls still work after the mid-qualification reset.
        En_n = 1'b0;
        cyc(10);
        En_n = 1'b1;
        cyc(10);
        expect_now("post_reset_enable", 8'hFF, 3'd0, 1'b0);
        Step_n = 1'b0;
        cyc(10);
        Step_n = 1'b1;
        cyc(10);
        expect_now("post_reset_step", 8'hFF, 3'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_sel_ctrl.md
KEY_SEL_CTRL -- requirements
Module: key_sel_ctrl

Interface
REQ-001 Parameter CNT_MAX, default 1000000, is the number of consecutive stable cycles needed to accept a new key level (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Key_Raw  input  8  raw active-low data push-buttons, asynchronous to Clk.
REQ-005 Step_n  input  1  raw active-low "next channel" push-button, asynchronous.
REQ-006 En_n  input  1  raw active-low "enable toggle" push-button, asynchronous.
REQ-007 Dir  input  1  slide switch, asynchronous level; 0 = count up, 1 = count down.
REQ-008 Key_Out  output  8  debounced Key_Raw levels, active-low; these drive the 8:1 selector data inputs.
REQ-009 Sel_Out  output  3  channel select; drives the selector's SW_In.
REQ-010 CSn_Out  output  1  active-low selector enable; drives the selector's CSn.

Function
REQ-011 Each of the 10 button inputs and Dir SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Each of the 10 button channels SHALL have an independent debouncer with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 RELEASED goes to PRESS_WAIT when the synced level is 0; PRESS_WAIT goes to PRESSED after CNT_MAX consecutive 0 samples, or back to RELEASED on any 1 sample, which clears the counter.
REQ-014 PRESSED goes to RELEASE_WAIT when the synced level is 1; RELEASE_WAIT goes to RELEASED after CNT_MAX consecutive 1 samples, or back to PRESSED on any 0 sample, which clears the counter.
REQ-015 The debounced level SHALL be 0 in PRESSED and RELEASE_WAIT, and 1 otherwise.
REQ-016 A clean raw level change SHALL appear on the debounced level exactly CNT_MAX+2 cycles after the first rising edge that samples the change.
REQ-017 A glitch lasting fewer than CNT_MAX synced cycles SHALL produce no change on any output.
REQ-018 Each debouncer SHALL emit a one-cycle press pulse in the cycle it enters PRESSED from PRESS_WAIT; no pulse SHALL be emitted on release.
REQ-019 The debounce counter width SHALL be clog2(CNT_MAX+1) and the counter SHALL saturate, never wrap.
REQ-020 Key_Out[i] SHALL equal the debounced level of Key_Raw[i].
REQ-021 The En press pulse SHALL toggle CSn_Out.
REQ-022 When CSn_Out=0, a Step press pulse SHALL change Sel_Out by +1 if synced Dir=0 or by -1 if synced Dir=1, modulo 8 (7 to 0 up, 0 to 7 down).
REQ-023 When CSn_Out=1, Step press pulses SHALL be ignored and Sel_Out SHALL hold.
REQ-024 If Step and En press pulses occur in the same cycle, the Step decision SHALL use the CSn_Out value from before that cycle's toggle.
REQ-025 Holding a button SHALL produce exactly one press pulse; there is no auto-repeat.
REQ-026 Key_Out, Sel_Out and CSn_Out SHALL be registered outputs.

Reset
REQ-027 Reset=1 at a rising edge SHALL place every debouncer in RELEASED with its counter at 0, clear every synchronizer to 1 (Dir synchronizer to 0), and set Key_Out=8'hFF, Sel_Out=3'd0 and CSn_Out=1.
REQ-028 Reset asserted mid-debounce SHALL abandon the pending transition with no press pulse; after release, a still-held button SHALL need a full CNT_MAX qualification before it is recognised.
REQ-029 Reset SHALL take priority over all other events in the same cycle.

Structure
REQ-030 A shared package SHALL hold the 2-bit debouncer state encodings (RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3) and the default CNT_MAX.
REQ-031 One sub-module, key_filter (synchronizer, debouncer FSM, counter, press pulse; parameter CNT_MAX), SHALL be instantiated 10 times; the Sel and CSn logic SHALL live in the top level.

Verification (CNT_MAX=4)
REQ-032 Key_Raw[3] driven 1 to 0 and held: Key_Out[3] falls exactly 6 cycles after the first sampling edge, and all other bits stay 1.
REQ-033 A 3-cycle low pulse on Key_Raw[5]: Key_Out stays 8'hFF and no press pulse occurs.
REQ-034 After reset, a clean En press followed by 9 clean Step presses with Dir=0: CSn_Out=0 and Sel_Out steps 1,2,...,7,0,1.
REQ-035 With Dir=1 and Sel_Out=0, one Step press gives Sel_Out=7; a second En press then sets CSn_Out=1, and a further Step press leaves Sel_Out=7.
REQ-036 Step_n and En_n pressed in the same cycle while CSn_Out=1: CSn_Out becomes 0 and Sel_Out is unchanged.
REQ-037 Reset asserted 2 cycles into a Step qualification and released with Step_n still low: Sel_Out=0 and CSn_Out=1 immediately after reset; a new qualification starts, and because CSn_Out=1 the resulting press leaves Sel_Out at 0.
